lpc_multi_channel: RTL

Multi-channel low-power buffer with full Q-channel handshake, including denial. NUM_CH independent write-to-read FIFOs sit between upstream producers and a downstream consumer. A clock/power controller can request quiescence over QREQn/QACCEPTn/QDENY. The block flushes upstream, drains every FIFO and then accepts; if quiescence is not reached in time, it denies.

---
 rtl/lpc_pkg.sv | 21 ++
 rtl/lpc_multi_channel_if.sv | 24 ++
 rtl/lpc_fifo.sv | 71 +++++++
 rtl/lpc_multi_channel.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared types and reset constants for the low-power multi-channel buffer
package lpc_pkg;

    typedef enum logic [2:0] {
        Q_RUN,
        Q_REQUEST,
        Q_STOPPED,
        Q_EXIT,
        Q_DENIED,
        Q_CONTINUE
    } q_state_t;

    localparam logic QACCEPTN_RST = 1'b1;
    localparam logic QDENY_RST    = 1'b0;

    // Writes are refused while the block is quiescent or unwinding from quiescence
    function automatic logic writes_blocked(input q_state_t s);
        return (s == Q_STOPPED) || (s == Q_EXIT);
    endfunction

endpackage

// File: rtl/lpc_multi_channel_if.sv
// rtl/lpc_multi_channel_if.sv - per-channel write/read stream bundle
interface lpc_multi_channel_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        wr_valid_i;
    logic [NUM_CH-1:0]        wr_ready_o;
    logic [NUM_CH*DATA_W-1:0] wr_data_i;
    logic [NUM_CH-1:0]        wr_flush_o;
    logic [NUM_CH-1:0]        wr_done_i;
    logic [NUM_CH-1:0]        rd_valid_o;
    logic [NUM_CH-1:0]        rd_ready_i;
    logic [NUM_CH*DATA_W-1:0] rd_data_o;

    modport slave (
        input  wr_valid_i, wr_data_i, wr_done_i, rd_ready_i,
        output wr_ready_o, wr_flush_o, rd_valid_o, rd_data_o
    );

    modport master (
        output wr_valid_i, wr_data_i, wr_done_i, rd_ready_i,
        input  wr_ready_o, wr_flush_o, rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/lpc_fifo.sv
// rtl/lpc_fifo.sv - single-channel circular FIFO with zeroed head when empty
module lpc_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    // A full FIFO refuses the push even if the head is popped in the same cycle
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rptr_q];

    // Pointer advance with wrap at DEPTH, and occupancy update
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lpc_multi_channel.sv
// rtl/lpc_multi_channel.sv - multi-channel buffer with Q-channel quiescence; LPC_DENY_EN adds deny timeout
module lpc_multi_channel
    import lpc_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 6,
    parameter int NUM_CH       = 2,
    parameter int DENY_TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_wakeup_i,
    lpc_multi_channel_if.slave  bus,
    input  logic                qreqn_i,
    output logic                qacceptn_o,
    output logic                qdeny_o,
    output logic                qactive_o
);
    q_state_t                 state_q, state_d;
    logic                     qacceptn_q, qacceptn_d;
    logic [NUM_CH-1:0]        full, empty, push, pop, wr_ready;
    logic [NUM_CH-1:0]        flush_q, flush_d;
    logic [NUM_CH*DATA_W-1:0] rd_data;
    logic                     qactive_q, qactive_d;
    logic                     accept_cond;

`ifdef LPC_DENY_EN
    localparam int TIMER_W = $clog2(DENY_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DENY_TIMEOUT - 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               qdeny_q, qdeny_d;
    assign qdeny_o = qdeny_q;
`else
    logic unused_deny_timeout;
    assign unused_deny_timeout = (DENY_TIMEOUT != 0);
    assign qdeny_o = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            lpc_fifo #(
                .DATA_W(DATA_W),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk    (clk),
                .rst_n  (reset_n),
                .push_i (push[g]),
                .data_i (bus.wr_data_i[g*DATA_W +: DATA_W]),
                .pop_i  (pop[g]),
                .data_o (rd_data[g*DATA_W +: DATA_W]),
                .full_o (full[g]),
                .empty_o(empty[g])
            );
        end
    endgenerate

    assign wr_ready       = ~full & {NUM_CH{~writes_blocked(state_q)}};
    assign push           = bus.wr_valid_i & wr_ready;
    assign pop            = bus.rd_ready_i & ~empty;
    assign bus.wr_ready_o = wr_ready;
    assign bus.rd_valid_o = ~empty;
    assign bus.rd_data_o  = rd_data;
    assign bus.wr_flush_o = flush_q;
    assign qacceptn_o     = qacceptn_q;
    assign qactive_o      = qactive_q | if_wakeup_i;

    // Quiescence is safe only with nothing buffered and nothing arriving
    assign accept_cond = ~qreqn_i & (&empty) & (&bus.wr_done_i) & ~(|bus.wr_valid_i);

    // Q-channel next state, handshake outputs and deny timer
    always_comb begin
        state_d    = state_q;
        qacceptn_d = qacceptn_q;
`ifdef LPC_DENY_EN
        qdeny_d    = qdeny_q;
        timer_d    = timer_q;
`endif
        case (state_q)
            Q_RUN: begin
                if (!qreqn_i) begin
                    state_d = Q_REQUEST;
`ifdef LPC_DENY_EN
                    timer_d = '0;
`endif
                end
            end
            Q_REQUEST: begin
                if (accept_cond) begin
                    state_d    = Q_STOPPED;
                    qacceptn_d = 1'b0;
                end
`ifdef LPC_DENY_EN
                else if (timer_q == TIMER_LAST) begin
                    state_d = Q_DENIED;
                    qdeny_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end
            Q_STOPPED: begin
                if (qreqn_i) begin
                    state_d = Q_EXIT;
                end
            end
            Q_EXIT: begin
                state_d    = Q_RUN;
                qacceptn_d = 1'b1;
            end
`ifdef LPC_DENY_EN
            Q_DENIED: begin
                if (qreqn_i) begin
                    state_d = Q_CONTINUE;
                    qdeny_d = 1'b0;
                end
            end
            Q_CONTINUE: begin
                state_d = Q_RUN;
            end
`endif
            default: begin
                state_d = Q_RUN;
            end
        endcase
    end

    // Flush stays requested until the producer reports done, even past REQUEST
    always_comb begin
        flush_d   = ({NUM_CH{state_q == Q_REQUEST}} | flush_q) & ~bus.wr_done_i;
        qactive_d = (|(~empty)) | (|bus.wr_valid_i) | (|bus.rd_ready_i);
    end

    // Q-channel state and handshake registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= Q_RUN;
            qacceptn_q <= QACCEPTN_RST;
`ifdef LPC_DENY_EN
            qdeny_q    <= QDENY_RST;
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            qacceptn_q <= qacceptn_d;
`ifdef LPC_DENY_EN
            qdeny_q    <= qdeny_d;
            timer_q    <= timer_d;
`endif
        end
    end

    // Flush and activity registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_q   <= '0;
            qactive_q <= 1'b0;
        end else begin
            flush_q   <= flush_d;
            qactive_q <= qactive_d;
        end
    end

endmodule
